// File: rtl/regfile_read_arbiter_if.sv
// Shared register-file read port bundle: four requesters, the arbiter's grant/select,
// the read-mux return path and the registered read result.
interface regfile_read_arbiter_if;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned IDW  = 2;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic               hold;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      sel;
    logic [DW-1:0]      mux_data;
    logic               rd_valid;
    logic [IDW-1:0]     rd_id;
    logic [DW-1:0]      rd_data;

    // Requester/register-file side
    modport master (
        output req, addr, hold, mux_data,
        input  gnt, sel, rd_valid, rd_id, rd_data
    );

    // Arbiter side
    modport slave (
        input  req, addr, hold, mux_data,
        output gnt, sel, rd_valid, rd_id, rd_data
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32-entry register-file read port among four requesters;
// grant/select are combinational, read data returns registered one cycle later with its ID.
module regfile_read_arbiter (
    input  logic                  clock,
    input  logic                  reset_n,
    regfile_read_arbiter_if.slave bus
);
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned IDW  = 2;

    logic [IDW-1:0]          ptr_q, ptr_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [IDW-1:0]          rd_id_q, rd_id_d;
    logic [DW-1:0]           rd_data_q, rd_data_d;

    logic [NREQ-1:0][AW-1:0] addr_a;
    logic [IDW-1:0]          scan_idx;
    logic                    win_found;
    logic [IDW-1:0]          win_id;
    logic [AW-1:0]           win_addr;
    logic                    xfer;
    logic [NREQ-1:0]         gnt_c;
    logic [AW-1:0]           sel_c;

    assign addr_a = bus.addr;

    // Scan from the priority pointer; the 2-bit add wraps naturally mod 4
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + IDW'(k);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    // Grant only outside reset and stall; the winner's req is high by construction
    always_comb begin
        xfer     = win_found && !bus.hold && reset_n;
        win_addr = addr_a[win_id];
        gnt_c    = '0;
        sel_c    = '0;
        if (xfer) begin
            gnt_c[win_id] = 1'b1;
            sel_c         = win_addr;
        end
    end

    assign bus.gnt = gnt_c;
    assign bus.sel = sel_c;

    // Next state: r0 reads as zero whatever the mux tree presents
    always_comb begin
        ptr_d      = ptr_q;
        rd_valid_d = 1'b0;
        rd_id_d    = rd_id_q;
        rd_data_d  = rd_data_q;
        if (xfer) begin
            ptr_d      = win_id + IDW'(1);
            rd_valid_d = 1'b1;
            rd_id_d    = win_id;
            rd_data_d  = (win_addr == AW'(0)) ? DW'(0) : bus.mux_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: a round-robin model predicts each grant and
// queues the expected read result, which is popped when the registered output appears.
module tb_regfile_read_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [31:0] regs [32];
    logic [4:0]  a [4];
    exp_t        sb [$];
    int          m_ptr;
    logic [1:0]  last_id;
    logic [31:0] last_data;
    int          checks;
    int          passes;

    regfile_read_arbiter_if bif ();

    regfile_read_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    assign bif.mux_data = regs[bif.sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check grant/select, then check the registered result
    task automatic cycle(input logic [3:0] r, input logic h, input logic rn, input string tag);
        int         w;
        logic       xfer;
        logic [4:0] wa;
        exp_t       e;
        bif.req  = r;
        bif.hold = h;
        bif.addr = {a[3], a[2], a[1], a[0]};
        reset_n  = rn;
        #1;
        xfer = 1'b0;
        w    = 0;
        if (rn && !h) begin
            for (int k = 0; k < 4; k++) begin
                if (!xfer && r[(m_ptr + k) % 4]) begin
                    xfer = 1'b1;
                    w    = (m_ptr + k) % 4;
                end
            end
        end
        wa = xfer ? a[w] : 5'd0;
        chk({tag, ".gnt"}, 64'(bif.gnt), xfer ? 64'(4'b0001 << w) : 64'd0);
        chk({tag, ".sel"}, 64'(bif.sel), 64'(wa));
        if (xfer) begin
            e.id   = 2'(w);
            e.data = (wa == 5'd0) ? 32'd0 : regs[wa];
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (!rn) begin
            m_ptr     = 0;
            sb.delete();
            last_id   = 2'd0;
            last_data = 32'd0;
        end else if (xfer) begin
            m_ptr = (w + 1) % 4;
        end
        if (sb.size() != 0) begin
            e         = sb.pop_front();
            last_id   = e.id;
            last_data = e.data;
            chk({tag, ".rd_valid"}, 64'(bif.rd_valid), 64'd1);
        end else begin
            chk({tag, ".rd_valid"}, 64'(bif.rd_valid), 64'd0);
        end
        chk({tag, ".rd_id"},   64'(bif.rd_id),   64'(last_id));
        chk({tag, ".rd_data"}, 64'(bif.rd_data), 64'(last_data));
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        m_ptr     = 0;
        last_id   = 2'd0;
        last_data = 32'd0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i * 32'h0101);
        regs[0]  = 32'hFFFF_FFFF;
        regs[7]  = 32'hDEAD_BEEF;
        a[0] = 5'd3; a[1] = 5'd5; a[2] = 5'd9; a[3] = 5'd12;
        bif.req  = '0;
        bif.hold = 1'b0;
        bif.addr = '0;
        reset_n  = 1'b0;

        // Reset with all requesters active: nothing granted
        cycle(4'b1111, 1'b0, 1'b0, "rst0");
        cycle(4'b1111, 1'b0, 1'b0, "rst1");

        // Round robin from reset: 0,1,2,3,0
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, 1'b1, $sformatf("rr%0d", i));

        // Single requester 2 reading r7
        a[2] = 5'd7;
        cycle(4'b0100, 1'b0, 1'b1, "single");
        cycle(4'b0000, 1'b0, 1'b1, "idle");
        // Pointer now at 3: requester 3 wins, then wraps to 0
        cycle(4'b1001, 1'b0, 1'b1, "wrap3");
        cycle(4'b0001, 1'b0, 1'b1, "wrap0");

        // Register zero reads as zero despite the mux driving all ones
        a[1] = 5'd0;
        cycle(4'b0010, 1'b0, 1'b1, "r0");

        // Hold freezes arbitration; then pointer order resumes
        for (int i = 0; i < 3; i++) cycle(4'b0011, 1'b1, 1'b1, $sformatf("hold%0d", i));
        cycle(4'b0011, 1'b0, 1'b1, "unhold0");
        cycle(4'b0010, 1'b0, 1'b1, "unhold1");

        // Back-to-back transfers from a lone requester
        a[3] = 5'd31;
        cycle(4'b1000, 1'b0, 1'b1, "b2b0");
        cycle(4'b1000, 1'b0, 1'b1, "b2b1");

        // Mid-stream reset: requester 2 granted, then reset discards pointer state
        a[0] = 5'd4; a[1] = 5'd6; a[2] = 5'd17;
        cycle(4'b0100, 1'b0, 1'b1, "mid_gnt2");
        cycle(4'b0111, 1'b0, 1'b0, "mid_rst");
        cycle(4'b0111, 1'b0, 1'b1, "mid_rel0");
        cycle(4'b0110, 1'b0, 1'b1, "mid_rel1");
        cycle(4'b0100, 1'b0, 1'b1, "mid_rel2");
        cycle(4'b0000, 1'b0, 1'b1, "tail");

        if (sb.size() != 0) chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
